// File: rtl/harvard_isa_pkg.sv
// Harvard ISA shared definitions: opcodes, field positions, instruction encoder and
// loader FSM state codes. Shared between the instruction decoder and the program loader.
package harvard_isa_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned MADDR_W = 8;
    localparam int unsigned IMM_W   = 16;

    // Field LSB positions inside the 32-bit instruction word
    localparam int unsigned OP_LSB      = 26;
    localparam int unsigned RD2_LSB     = 21;
    localparam int unsigned RD1_LSB     = 16;
    localparam int unsigned ST_ADDR_LSB = 18;
    localparam int unsigned RS2_LSB     = 5;
    localparam int unsigned LO_LSB      = 0;

    localparam logic [OP_W-1:0] OP_MOVI  = 6'h00;
    localparam logic [OP_W-1:0] OP_MOV   = 6'h01;
    localparam logic [OP_W-1:0] OP_LOAD  = 6'h02;
    localparam logic [OP_W-1:0] OP_STORE = 6'h03;
    localparam logic [OP_W-1:0] OP_ADD   = 6'h04;
    localparam logic [OP_W-1:0] OP_SUB   = 6'h05;
    localparam logic [OP_W-1:0] OP_MUL   = 6'h06;
    localparam logic [OP_W-1:0] OP_AND   = 6'h07;
    localparam logic [OP_W-1:0] OP_OR    = 6'h08;
    localparam logic [OP_W-1:0] OP_XOR   = 6'h09;
    localparam logic [OP_W-1:0] OP_NAND  = 6'h0A;
    localparam logic [OP_W-1:0] OP_NOR   = 6'h0B;
    localparam logic [OP_W-1:0] OP_XNOR  = 6'h0C;
    localparam logic [OP_W-1:0] OP_CMP   = 6'h0D;
    localparam logic [OP_W-1:0] OP_SHL   = 6'h0E;
    localparam logic [OP_W-1:0] OP_SHR   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LRSH  = 6'h10;

    // Loader FSM state codes
    localparam int unsigned     ST_W     = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   rd2;
        logic [REG_W-1:0]   rd1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rs1;
        logic [MADDR_W-1:0] addr;
        logic [IMM_W-1:0]   imm;
    } instr_fields_t;

    // Pack fields into an instruction word; unused bits stay zero, unknown ops are R-type
    function automatic logic [INSTR_W-1:0] encode_instr(input instr_fields_t f);
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OP_LSB +: OP_W] = f.op;
        case (f.op)
            OP_MOVI: begin
                w[RD2_LSB +: REG_W] = f.rd2;
                w[LO_LSB +: IMM_W]  = f.imm;
            end
            OP_MOV: begin
                w[RD2_LSB +: REG_W] = f.rd2;
                w[LO_LSB +: REG_W]  = f.rs2;
            end
            OP_LOAD: begin
                w[RD2_LSB +: REG_W]  = f.rd2;
                w[LO_LSB +: MADDR_W] = f.addr;
            end
            OP_STORE: begin
                w[ST_ADDR_LSB +: MADDR_W] = f.addr;
                w[LO_LSB +: REG_W]        = f.rs2;
            end
            default: begin
                w[RD2_LSB +: REG_W] = f.rd2;
                w[RD1_LSB +: REG_W] = f.rd1;
                w[RS2_LSB +: REG_W] = f.rs2;
                w[LO_LSB +: REG_W]  = f.rs1;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded instruction words.
// Ports: clk, rst_n (async active-low), i_push/i_wdata write side, i_pop/o_rdata read
// side (o_rdata is the current head), o_full/o_empty status flags.
module instr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage (no reset needed; occupancy is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes opcode/operand fields into 32-bit instruction words, buffers
// them in a small FIFO and writes them sequentially into IMEM with back-pressure.
// Ports: clk, rst_n; load_start/load_base open a session; in_valid/in_ready/in_last and
// in_op/in_rd2/in_rd1/in_rs2/in_rs1/in_addr/in_imm carry fields; imem_we/imem_addr/
// imem_wdata/imem_ready form the IMEM write port; busy, done, wrap_err report status.
// Build option ENC_ILLEGAL_CHECK_EN: drops opcodes above OP_LRSH and adds sticky illegal_op.
module instr_encoder_loader
    import harvard_isa_pkg::*;
#(
    parameter int unsigned IMEM_AW    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic [IMEM_AW-1:0] load_base,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [5:0]         in_op,
    input  logic [4:0]         in_rd2,
    input  logic [4:0]         in_rd1,
    input  logic [4:0]         in_rs2,
    input  logic [4:0]         in_rs1,
    input  logic [7:0]         in_addr,
    input  logic [15:0]        in_imm,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    input  logic               imem_ready,
    output logic               busy,
    output logic               done,
    output logic               wrap_err
`ifdef ENC_ILLEGAL_CHECK_EN
    ,
    output logic               illegal_op
`endif
);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_nxt;
    logic [IMEM_AW-1:0] r_addr;
    logic               r_wrap_err;
    instr_fields_t      w_fields;
    logic [INSTR_W-1:0] w_enc;
    logic [INSTR_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_ready;
    logic               w_accept;
    logic               w_illegal;
    logic               w_push;
    logic               w_we;
    logic               w_pop;
    logic               w_start;

    // Field bundle and combinational encode into the FIFO write port
    always_comb begin
        w_fields      = '0;
        w_fields.op   = in_op;
        w_fields.rd2  = in_rd2;
        w_fields.rd1  = in_rd1;
        w_fields.rs2  = in_rs2;
        w_fields.rs1  = in_rs1;
        w_fields.addr = in_addr;
        w_fields.imm  = in_imm;
    end
    assign w_enc = encode_instr(w_fields);

`ifdef ENC_ILLEGAL_CHECK_EN
    assign w_illegal = (in_op > OP_LRSH);
`else
    assign w_illegal = 1'b0;
`endif

    assign w_start  = (r_state == ST_IDLE) & load_start;
    assign w_ready  = (r_state == ST_RUN) & ~w_full;
    assign w_accept = in_valid & w_ready;
    assign w_push   = w_accept & ~w_illegal;
    assign w_we     = ~w_empty & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
    assign w_pop    = w_we & imem_ready;

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_enc),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; DRAIN waits until the last queued word has left the FIFO
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (load_start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && in_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Write address and sticky wrap flag; the write at the top address still happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wrap_err <= 1'b0;
        end else if (w_start) begin
            r_addr     <= load_base;
            r_wrap_err <= 1'b0;
        end else if (w_pop) begin
            r_addr <= r_addr + IMEM_AW'(1);
            if (&r_addr) r_wrap_err <= 1'b1;
        end
    end

`ifdef ENC_ILLEGAL_CHECK_EN
    logic r_illegal_op;

    // Sticky illegal-opcode flag, cleared when a new session opens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_illegal_op <= 1'b0;
        else if (w_start)                r_illegal_op <= 1'b0;
        else if (w_accept && w_illegal)  r_illegal_op <= 1'b1;
    end
    assign illegal_op = r_illegal_op;
`endif

    assign in_ready   = w_ready;
    assign imem_we    = w_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_we ? w_head : '0;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign wrap_err   = r_wrap_err;

endmodule
